// File: rtl/ifm_rsp_if.sv
// Address-request and returned-word streams between the feature-memory requester and ifm_rsp.
// The requester uses the master modport; the responder uses the slave modport.
interface ifm_rsp_if #(
  parameter int DW = 8,
  parameter int DN = 8,
  parameter int AW = 14
);
  logic [AW-1:0]    ifm_addr;
  logic             ifm_addr_first;
  logic             ifm_addr_last;
  logic             ifm_addr_valid;
  logic             ifm_addr_ready;
  logic [DN*DW-1:0] s_data;
  logic             s_first;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output ifm_addr, ifm_addr_first, ifm_addr_last, ifm_addr_valid,
    input  ifm_addr_ready,
    input  s_data, s_first, s_last, s_valid,
    output s_ready
  );

  modport slave (
    input  ifm_addr, ifm_addr_first, ifm_addr_last, ifm_addr_valid,
    output ifm_addr_ready,
    output s_data, s_first, s_last, s_valid,
    input  s_ready
  );
endinterface

// File: rtl/ifm_rsp.sv
// Feature-memory read responder: one SRAM read per accepted address, words returned through a credit-managed FIFO.
// Define IFM_RSP_RDREG_EN to register mem_rdata before the FIFO (read latency 3 instead of 2).
module ifm_rsp #(
  parameter int DW    = 8,
  parameter int DN    = 8,
  parameter int AW    = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ifm_rsp_if.slave         bus,
  output logic             mem_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [DN*DW-1:0] mem_rdata,
  output logic             busy
);
  localparam int WW = DN * DW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  logic              acc;
  logic              push;
  logic              pop;
  logic [WW+1:0]     push_word;
  logic [WW+1:0]     head;
  logic [1:0]        infl_cnt;
  logic [CW:0]       occ;
  logic              vld_p1_q;
  logic              first_p1_q;
  logic              last_p1_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WW+1:0]     fifo_q [DEPTH];

  // Every read in flight already owns a FIFO slot, so a push can never overflow.
  assign occ                = {1'b0, count_q} + {{(CW-1){1'b0}}, infl_cnt};
  assign bus.ifm_addr_ready = rst_n & (occ < DEPTH_OCC);
  assign acc                = bus.ifm_addr_valid & bus.ifm_addr_ready;
  assign mem_en             = acc;
  assign mem_addr           = bus.ifm_addr;

  // ---- stage p1: SRAM read cycle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= acc;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      first_p1_q <= bus.ifm_addr_first;
      last_p1_q  <= bus.ifm_addr_last;
    end
  end

`ifdef IFM_RSP_RDREG_EN
  logic          vld_p2_q;
  logic          first_p2_q;
  logic          last_p2_q;
  logic [WW-1:0] rdata_p2_q;

  // ---- stage p2: registered read data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2_q <= 1'b0;
    else        vld_p2_q <= vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (vld_p1_q) begin
      first_p2_q <= first_p1_q;
      last_p2_q  <= last_p1_q;
      rdata_p2_q <= mem_rdata;
    end
  end

  assign push      = vld_p2_q;
  assign push_word = {rdata_p2_q, first_p2_q, last_p2_q};
  assign infl_cnt  = {1'b0, vld_p1_q} + {1'b0, vld_p2_q};
`else
  assign push      = vld_p1_q;
  assign push_word = {mem_rdata, first_p1_q, last_p1_q};
  assign infl_cnt  = {1'b0, vld_p1_q};
`endif

  // ---- return FIFO ----
  assign pop = (count_q != '0) & bus.s_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_word;
  end

  // Storage is never reset; the empty FIFO presents zeros instead.
  assign head        = fifo_q[rd_ptr_q];
  assign bus.s_valid = (count_q != '0);
  assign bus.s_data  = bus.s_valid ? head[WW+1:2] : '0;
  assign bus.s_first = bus.s_valid & head[1];
  assign bus.s_last  = bus.s_valid & head[0];
  assign busy        = (infl_cnt != 2'd0) | (count_q != '0);
endmodule

// File: tb/tb_ifm_rsp.sv
// Testbench for ifm_rsp: SRAM model, queue-based expected-stream model and directed bursts.
module tb_ifm_rsp;
  localparam int DW    = 8;
  localparam int DN    = 8;
  localparam int AW    = 14;
  localparam int DEPTH = 4;
  localparam int WW    = DN * DW;
`ifdef IFM_RSP_RDREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [63:0] d;
    logic        f;
    logic        l;
    int          t;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_rdata;
  logic          busy;

  ifm_rsp_if #(.DW(DW), .DN(DN), .AW(AW)) bus ();

  ifm_rsp #(.DW(DW), .DN(DN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_total = 0;
  int   acc_c = -1;
  int   vld_c = -1;
  logic arm_lat = 1'b0;
  logic rnd_on = 1'b0;
  ent_t q[$];
  ent_t got[$];
  ent_t h;
  logic exp_vld;
  logic acc_now;

  function automatic logic [63:0] mword(input logic [13:0] a);
    return {16'hC0DE, 2'b00, a, 18'd0, a ^ 14'h3FFF};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Synchronous SRAM: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mword(mem_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model: every accepted address becomes one word, visible LAT cycles later, in accept order.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_s_valid", bus.s_valid, 0);
      chk("rst_busy",    busy,        0);
      chk("rst_s_first", bus.s_first, 0);
      chk("rst_s_last",  bus.s_last,  0);
      chk("rst_s_data",  bus.s_data,  0);
      chk("rst_mem_en",  mem_en,      0);
    end else begin
      exp_vld = (q.size() > 0) && (q[0].t + LAT <= cyc);
      chk("ready",   bus.ifm_addr_ready, q.size() < DEPTH);
      chk("s_valid", bus.s_valid, exp_vld);
      chk("busy",    busy, q.size() > 0);
      acc_now = bus.ifm_addr_valid & bus.ifm_addr_ready;
      chk("mem_en", mem_en, acc_now);
      if (acc_now) chk("mem_addr", mem_addr, bus.ifm_addr);
      if (arm_lat && bus.s_valid && bus.s_first && vld_c < 0) vld_c = cyc;
      if (bus.s_valid && exp_vld) begin
        h = q[0];
        chk("s_data",  bus.s_data,  h.d);
        chk("s_first", bus.s_first, h.f);
        chk("s_last",  bus.s_last,  h.l);
        if (bus.s_ready) begin
          void'(q.pop_front());
          got.push_back('{bus.s_data, bus.s_first, bus.s_last, cyc});
        end
      end
      if (acc_now) begin
        q.push_back('{mword(bus.ifm_addr), bus.ifm_addr_first, bus.ifm_addr_last, cyc});
        acc_total++;
        if (arm_lat && bus.ifm_addr_first && acc_c < 0) acc_c = cyc;
      end
      chk("occ_bound", q.size() <= DEPTH, 1);
    end
  end

  task automatic send(input logic [13:0] a, input logic f, input logic l);
    int n;
    bus.ifm_addr       = a;
    bus.ifm_addr_first = f;
    bus.ifm_addr_last  = l;
    bus.ifm_addr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.ifm_addr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: addr %h not accepted after %0d cycles, required accept", a, n);
    end
    @(posedge clk);
    #1;
    bus.ifm_addr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || bus.s_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: busy still %0d after %0d cycles, required 0", busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    logic [13:0] base;
    rst_n              = 1'b0;
    bus.ifm_addr       = '0;
    bus.ifm_addr_first = 1'b0;
    bus.ifm_addr_last  = 1'b0;
    bus.ifm_addr_valid = 1'b0;
    bus.s_ready        = 1'b0;
    mem_rdata          = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single three-word burst with a free-running sink
    bus.s_ready = 1'b1;
    got.delete();
    arm_lat = 1'b1;
    send(14'h010, 1'b1, 1'b0);
    send(14'h011, 1'b0, 1'b0);
    send(14'h012, 1'b0, 1'b1);
    drain();
    arm_lat = 1'b0;
    chk("burst_words", got.size(), 3);
    if (got.size() == 3) begin
      chk("burst_w0", got[0].d, 64'hC0DE0010_00003FEF);
      chk("burst_w1", got[1].d, 64'hC0DE0011_00003FEE);
      chk("burst_w2", got[2].d, 64'hC0DE0012_00003FED);
      chk("burst_f0", got[0].f, 1);
      chk("burst_l0", got[0].l, 0);
      chk("burst_f2", got[2].f, 0);
      chk("burst_l2", got[2].l, 1);
    end
    chk("latency", vld_c - acc_c, LAT);

    // Backpressure: only DEPTH addresses fit before the sink opens
    bus.s_ready = 1'b0;
    got.delete();
    acc_total = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(14'h200 + 14'(i), i == 0, i == 7);
      end
      begin
        repeat (12) @(negedge clk);
        chk("bp_accepted", acc_total, DEPTH);
        chk("bp_ready", bus.ifm_addr_ready, 0);
        @(posedge clk);
        #1 bus.s_ready = 1'b1;
      end
    join
    drain();
    chk("bp_words", got.size(), 8);
    if (got.size() == 8) begin
      chk("bp_w0", got[0].d, 64'hC0DE0200_00003DFF);
      chk("bp_w7", got[7].d, 64'hC0DE0207_00003DF8);
      chk("bp_f0", got[0].f, 1);
      chk("bp_l7", got[7].l, 1);
    end

    // 1000 addresses in random bursts against a random sink
    got.delete();
    acc_total = 0;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 bus.s_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        n = 0;
        while (n < 1000) begin
          len  = $urandom_range(1, 8);
          if (len > 1000 - n) len = 1000 - n;
          base = 14'($urandom_range(0, 16383));
          for (int j = 0; j < len; j++) send(base + 14'(j), j == 0, j == len - 1);
          n += len;
        end
        rnd_on = 1'b0;
      end
    join
    bus.s_ready = 1'b1;
    drain();
    chk("rand_accepted", acc_total, 1000);
    chk("rand_words", got.size(), 1000);

    // Continuous flow: simultaneous push/pop with pointer wrap
    got.delete();
    for (int i = 0; i < 10; i++) send(14'h3FF0 + 14'(i), i == 0, i == 9);
    drain();
    chk("flow_words", got.size(), 10);
    if (got.size() == 10) begin
      chk("flow_w0", got[0].d, 64'hC0DE3FF0_0000000F);
      chk("flow_w9", got[9].d, 64'hC0DE3FF9_00000006);
    end

    // Single-word burst at the top address
    got.delete();
    send(14'h3FFF, 1'b1, 1'b1);
    drain();
    chk("single_words", got.size(), 1);
    if (got.size() == 1) begin
      chk("single_w", got[0].d, 64'hC0DE3FFF_00000000);
      chk("single_f", got[0].f, 1);
      chk("single_l", got[0].l, 1);
    end

    // Reset with words buffered and a read in flight
    bus.s_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(14'h050 + 14'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_s_valid", bus.s_valid, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", bus.ifm_addr_ready, 1);
    @(posedge clk);
    #1;
    bus.s_ready = 1'b1;
    got.delete();
    send(14'h100, 1'b1, 1'b0);
    send(14'h101, 1'b0, 1'b1);
    drain();
    chk("postrst_words", got.size(), 2);
    if (got.size() == 2) begin
      chk("postrst_w0", got[0].d, 64'hC0DE0100_00003EFF);
      chk("postrst_w1", got[1].d, 64'hC0DE0101_00003EFE);
      chk("postrst_f0", got[0].f, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
